apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB completer that sits directly downstream of the team's APB bus driver.
- Terminates PSEL/PENABLE transfers into a DEPTH-word register file.
- Inserts a parameterised number of wait states before each completion, and flags illegal addresses with PSLVERR.
- It is the DUT the APB interface driver and monitor talk to.

Parameters:
- ADDR_WIDTH, 32, width of PADDR (byte address).
- DATA_WIDTH, 32, width of PWDATA/PRDATA (must be 32).
- DEPTH, 16, number of 32-bit registers (power of two, 2..256).
- WAIT_STATES, 1, ACCESS cycles with PREADY low before completion (0..15).

Ports:
- PCLK  in  1  bus clock; all state changes on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PADDR  in  ADDR_WIDTH  byte address.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase strobe.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  DATA_WIDTH  write data.
- PREADY  out  1  transfer completes this cycle.
- PRDATA  out  DATA_WIDTH  read data, valid while PREADY=1 on a read.
- PSLVERR  out  1  error response, valid only while PREADY=1.

Behaviour:
- Reset (PRESETn=0, async): state=IDLE, wait counter=0, all registers=0, PRDATA=0, PREADY=0, PSLVERR=0. Reset mid-transfer aborts it with no register update; the master must restart.
- Decode:
  - idx = PADDR[ADDR_WIDTH-1:2].
  - legal iff PADDR[1:0]==0 and idx<DEPTH.
  - Decode is sampled at SETUP; PADDR changes during ACCESS are ignored.
- FSM states IDLE, ACCESS:
  - IDLE: PREADY=0. On an edge with PSEL=1 and PENABLE=0 (setup phase):
    - latch idx, PWRITE, legal;
    - load counter=WAIT_STATES;
    - on a legal read, load PRDATA<=reg[idx];
    - go to ACCESS.
  - IDLE with PSEL=1 and PENABLE=1 and no prior setup: protocol violation, ignored, stay IDLE.
  - ACCESS, PSEL=1, PENABLE=1, counter>0: decrement counter, PREADY=0.
  - ACCESS, PSEL=1, PENABLE=1, counter==0: PREADY=1 combinationally. At that rising edge:
    - a legal write commits reg[idx]<=PWDATA (sampled at that edge);
    - go to IDLE.
  - ACCESS, PSEL=0 (master abort): return to IDLE, no write, PREADY stays 0.
- PREADY is combinational from state/counter/PSEL/PENABLE. It is high exactly one cycle per transfer and falls when PENABLE/PSEL drop, so the monitor sees a clean pulse.
- Latency: setup cycle + (WAIT_STATES+1) access cycles. With WAIT_STATES=0 a transfer takes 2 cycles.
- Back-to-back: a new setup (PSEL=1, PENABLE=0) on the cycle after completion is accepted normally from IDLE.
- Error response:
  - illegal address gives PSLVERR=1 with PREADY=1 after the same wait states;
  - no register write;
  - PRDATA=0 on an erroneous read.
  - PSLVERR=0 whenever PREADY=0.
- Read data: PRDATA holds its last loaded value between transfers. A write never changes PRDATA.
- A read and a write to the same register cannot overlap, since only one transfer is in flight.

Test Plan:
- Write/read, WAIT_STATES=1:
  - write PADDR=0x08, PWDATA=0xDEADBEEF, then read 0x08 -> PRDATA=0xDEADBEEF, PSLVERR=0.
  - each transfer = 1 setup + 2 access cycles; PREADY high exactly 1 cycle.
- Wait states: WAIT_STATES=0 -> PREADY high on the first PENABLE cycle (2-cycle transfer). WAIT_STATES=3 -> PREADY high on the 4th PENABLE cycle.
- Errors:
  - write PADDR=0x40 (idx 16, DEPTH=16) -> PREADY=1, PSLVERR=1, and a read of every register still returns its prior value.
  - read PADDR=0x05 (misaligned) -> PSLVERR=1, PRDATA=0.
- Reset mid-access:
  - write 0x04=0x12345678 completes;
  - start a write 0x04=0xFFFFFFFF and drop PRESETn during ACCESS -> PREADY=0 immediately;
  - after release, reading 0x04 returns 0x00000000 (regfile cleared).
- Abort: setup write 0x0C=0xA5A5A5A5, then PSEL=0 during an ACCESS wait cycle -> no PREADY, and reading 0x0C returns 0.
- Back-to-back: 16 writes idx*0x11111111 to 0x00..0x3C, then 16 reads with a 1-cycle gap -> all data match, no PSLVERR.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer terminating transfers into a DEPTH-word register file, with
// WAIT_STATES stall cycles per transfer and PSLVERR on misaligned/out-of-range addresses.
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                             state, state_nxt;
  logic   [3:0]                       cnt, cnt_nxt;
  logic   [IDX_W-1:0]                 idx_q;
  logic                               wr_q, legal_q;
  logic   [DEPTH-1:0][DATA_WIDTH-1:0] regs;

  logic             setup, legal;
  logic [IDX_W-1:0] idx;

  // DEPTH is a power of two, so "idx < DEPTH" reduces to the upper address bits being zero.
  assign setup = (state == IDLE) && PSEL && !PENABLE;
  assign idx   = PADDR[IDX_W+1:2];
  assign legal = (PADDR[1:0] == 2'b00) && (PADDR[ADDR_WIDTH-1:IDX_W+2] == '0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    PREADY    = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = ACCESS;
          cnt_nxt   = WS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_nxt = IDLE;
        end else if (PENABLE) begin
          if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
          end else begin
            PREADY    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign PSLVERR = PREADY && !legal_q;

  // Read data is fetched at setup so it is stable for the whole access phase.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      legal_q <= 1'b0;
      PRDATA  <= '0;
      regs    <= '0;
    end else begin
      if (setup) begin
        idx_q   <= idx;
        wr_q    <= PWRITE;
        legal_q <= legal;
        if (!PWRITE) PRDATA <= legal ? regs[idx] : '0;
      end
      if (PREADY && wr_q && legal_q) regs[idx_q] <= PWDATA;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: three instances (WAIT_STATES 1, 0, 3)
// share the bus signals and are selected through per-instance PSEL.
module tb_apb_slave_regfile;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [2:0]  psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [2:0]  pready, pslverr;
  logic [31:0] prdata [3];

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(1)) u_ws1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));
  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));
  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  typedef struct packed {
    logic        err;
    logic [7:0]  waits;
    logic [31:0] rdata;
  } resp_t;

  resp_t       sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mreg [3][16];
  logic [31:0] mprd [3];
  int          ws [3] = '{1, 0, 3};

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) mreg[d][i] = '0;
      mprd[d] = '0;
    end
  endtask

  // Reference model: predicts the completion response and PRDATA after it.
  task automatic push_exp(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    resp_t r;
    int    idx;
    bit    legal;
    idx   = int'(addr[31:2]);
    legal = (addr[1:0] == 2'b00) && (idx < 16);
    if (!wr) mprd[d] = legal ? mreg[d][idx] : 32'h0;
    else if (legal) mreg[d][idx] = wdata;
    r.err   = !legal;
    r.waits = 8'(ws[d]);
    r.rdata = mprd[d];
    sb.push_back(r);
  endtask

  // Bus driver; entered and left at posedge+1 with the bus idle.
  task automatic xfer(input int d, input bit gap, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output resp_t obs);
    int w;
    w = 0;
    if (gap) begin @(posedge PCLK); #1; end
    psel = '0; psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge PCLK); #1 penable = 1'b1;
    forever begin
      @(negedge PCLK);
      if (pready[d]) break;
      w++;
      if (w > 40) break;
      @(posedge PCLK); #1;
    end
    obs.err   = pslverr[d];
    obs.rdata = prdata[d];
    obs.waits = (w > 40) ? 8'hFF : 8'(w);
    @(posedge PCLK); #1 psel = '0; penable = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({pready[d], pslverr[d], prdata[d]} !== 34'h0) begin
        failures++;
        $display("FAIL reset dut%0d got rdy=%b err=%b data=%h want all zero", d, pready[d], pslverr[d], prdata[d]);
      end
    end
    #1 PRESETn = 1'b1;
    model_reset();
    @(posedge PCLK); #1;
  endtask

  task automatic test_write_read();
    resp_t obs, e;
    push_exp(0, 1, 32'h08, 32'hDEADBEEF);
    xfer(0, 1, 1, 32'h08, 32'hDEADBEEF, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL wr08 got %h want %h", obs, e); end
    @(negedge PCLK); checks++;
    if (pready[0] !== 1'b0) begin failures++; $display("FAIL ready_pulse got %b want 0", pready[0]); end
    push_exp(0, 0, 32'h08, 32'h0);
    xfer(0, 1, 0, 32'h08, 32'h0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rd08 got %h want %h", obs, e); end
  endtask

  task automatic test_wait_states();
    resp_t obs, e;
    for (int d = 1; d < 3; d++) begin
      push_exp(d, 1, 32'h10, 32'hCAFEF00D);
      xfer(d, 1, 1, 32'h10, 32'hCAFEF00D, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL ws_wr dut%0d got %h want %h", d, obs, e); end
      push_exp(d, 0, 32'h10, 32'h0);
      xfer(d, 1, 0, 32'h10, 32'h0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL ws_rd dut%0d got %h want %h", d, obs, e); end
    end
    push_exp(2, 1, 32'h44, 32'h1);
    xfer(2, 1, 1, 32'h44, 32'h1, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL ws_err dut2 got %h want %h", obs, e); end
  endtask

  task automatic test_protocol();
    resp_t obs, e;
    @(posedge PCLK); #1 psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h0BAD0BAD;
    repeat (2) begin
      @(negedge PCLK); checks++;
      if (pready[0] !== 1'b0) begin failures++; $display("FAIL no_setup got rdy=%b want 0", pready[0]); end
      @(posedge PCLK); #1;
    end
    psel = '0; penable = 1'b0;
    push_exp(0, 0, 32'h08, 32'h0);
    xfer(0, 1, 0, 32'h08, 32'h0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL no_setup_rd got %h want %h", obs, e); end
  endtask

  task automatic test_errors();
    resp_t obs, e;
    push_exp(0, 1, 32'h40, 32'h77777777);
    xfer(0, 1, 1, 32'h40, 32'h77777777, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL err_wr40 got %h want %h", obs, e); end
    for (int i = 0; i < 16; i++) begin
      push_exp(0, 0, 32'(i * 4), 32'h0);
      xfer(0, 1, 0, 32'(i * 4), 32'h0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL err_scan idx%0d got %h want %h", i, obs, e); end
    end
    push_exp(0, 0, 32'h08, 32'h0);
    xfer(0, 1, 0, 32'h08, 32'h0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL err_rd08 got %h want %h", obs, e); end
    push_exp(0, 0, 32'h05, 32'h0);
    xfer(0, 1, 0, 32'h05, 32'h0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL err_rd05 got %h want %h", obs, e); end
  endtask

  task automatic test_abort();
    resp_t obs, e;
    @(posedge PCLK); #1 psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hA5A5A5A5;
    @(posedge PCLK); #1 psel = '0;
    repeat (2) begin
      @(negedge PCLK); checks++;
      if (pready[0] !== 1'b0) begin failures++; $display("FAIL abort_rdy got %b want 0", pready[0]); end
      @(posedge PCLK); #1;
    end
    push_exp(0, 0, 32'h0C, 32'h0);
    xfer(0, 1, 0, 32'h0C, 32'h0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL abort_rd0c got %h want %h", obs, e); end
  endtask

  task automatic test_reset_mid();
    resp_t obs, e;
    push_exp(0, 1, 32'h04, 32'h12345678);
    xfer(0, 1, 1, 32'h04, 32'h12345678, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rst_wr04 got %h want %h", obs, e); end
    @(posedge PCLK); #1 psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hFFFFFFFF;
    @(posedge PCLK); #1 penable = 1'b1;
    @(posedge PCLK); #1; checks++;
    if (pready[0] !== 1'b1) begin failures++; $display("FAIL rst_pre_rdy got %b want 1", pready[0]); end
    PRESETn = 1'b0;
    #1; checks++;
    if ({pready[0], pslverr[0]} !== 2'b00) begin
      failures++; $display("FAIL rst_async got rdy=%b err=%b want 0 0", pready[0], pslverr[0]);
    end
    psel = '0; penable = 1'b0;
    model_reset();
    #2 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    push_exp(0, 0, 32'h04, 32'h0);
    xfer(0, 1, 0, 32'h04, 32'h0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rst_rd04 got %h want %h", obs, e); end
    push_exp(0, 0, 32'h08, 32'h0);
    xfer(0, 1, 0, 32'h08, 32'h0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rst_rd08 got %h want %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    resp_t obs, e;
    for (int i = 0; i < 16; i++) begin
      push_exp(0, 1, 32'(i * 4), 32'(i) * 32'h11111111);
      xfer(0, (i == 0), 1, 32'(i * 4), 32'(i) * 32'h11111111, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL b2b_wr idx%0d got %h want %h", i, obs, e); end
    end
    for (int i = 0; i < 16; i++) begin
      push_exp(0, 0, 32'(i * 4), 32'h0);
      xfer(0, 1, 0, 32'(i * 4), 32'h0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL b2b_rd idx%0d got %h want %h", i, obs, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_wait_states();
    test_protocol();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
